// File: rtl/bus_monitor_pkg.sv
// rtl/bus_monitor_pkg.sv - shared constants, types and helpers for the bus_monitor AXI4-Lite register block
package bus_monitor_pkg;

  // Word indices of the register map (byte address bits [4:2])
  localparam logic [2:0] REG_CTRL0     = 3'd0;
  localparam logic [2:0] REG_CTRL1     = 3'd1;
  localparam logic [2:0] REG_CTRL2     = 3'd2;
  localparam logic [2:0] REG_CTRL3     = 3'd3;
  localparam logic [2:0] REG_STATUS0   = 3'd4;
  localparam logic [2:0] REG_STATUS1   = 3'd5;
  localparam logic [2:0] REG_EVENT_CNT = 3'd6;
  localparam logic [2:0] REG_ID        = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Merge new data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Control words and the counter accept writes; status and ID words answer SLVERR.
  function automatic logic is_writable(input logic [2:0] idx);
    return (idx <= REG_CTRL3) || (idx == REG_EVENT_CNT);
  endfunction

endpackage

// File: rtl/bus_monitor_event_cnt.sv
// rtl/bus_monitor_event_cnt.sv - saturating 32-bit event counter where a clear beats a same-cycle event
module bus_monitor_event_cnt
  import bus_monitor_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        event_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (event_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bus_monitor_axil_slave.sv
// rtl/bus_monitor_axil_slave.sv - AXI4-Lite register block: 4 ctrl words, 2 status words, event counter, ID
module bus_monitor_axil_slave
  import bus_monitor_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE         = 32'h0B05_0100
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [31:0]                       status0_i,
  input  logic [31:0]                       status1_i,
  input  logic                              event_i,
  output logic [31:0]                       ctrl0_o,
  output logic [31:0]                       ctrl1_o,
  output logic [31:0]                       ctrl2_o,
  output logic [31:0]                       ctrl3_o
);

  // Write channel state
  wr_state_t        wr_state_q, wr_state_d;
  logic             aw_have_q, aw_have_d;
  logic [2:0]       aw_idx_q, aw_idx_d;
  logic             w_have_q, w_have_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [3:0][31:0] ctrl_q, ctrl_d;

  logic             aw_hs, w_hs, wr_commit, cnt_clr;
  logic [2:0]       wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;

  // Read channel state
  rd_state_t        rd_state_q, rd_state_d;
  logic             arready_q, arready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             ar_hs;
  logic [31:0]      rd_word;
  logic [31:0]      cnt_value;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  bus_monitor_event_cnt u_event_cnt (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .clr_i   (cnt_clr),
    .event_i (event_i),
    .count_o (cnt_value)
  );

  // Write FSM: capture AW and W independently, commit the cycle the second one lands.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_have_d  = aw_have_q;
    aw_idx_d   = aw_idx_q;
    w_have_d   = w_have_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_q;
    cnt_clr    = 1'b0;
    wr_commit  = 1'b0;
    aw_hs      = S_AXI_AWVALID && awready_q;
    w_hs       = S_AXI_WVALID && wready_q;
    // Use the live bus value when a handshake completes the pair this cycle.
    wr_idx     = aw_have_q ? aw_idx_q : S_AXI_AWADDR[4:2];
    wr_data    = w_have_q ? w_data_q : S_AXI_WDATA[31:0];
    wr_strb    = w_have_q ? w_strb_q : S_AXI_WSTRB[3:0];
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          w_data_d = S_AXI_WDATA[31:0];
          w_strb_d = S_AXI_WSTRB[3:0];
        end
        wr_commit = (aw_have_q || aw_hs) && (w_have_q || w_hs);
        if (wr_commit) begin
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
          wr_state_d = WR_RESP;
          bresp_d    = is_writable(wr_idx) ? RESP_OKAY : RESP_SLVERR;
          if (wr_idx <= REG_CTRL3) begin
            ctrl_d[wr_idx[1:0]] = apply_wstrb(ctrl_q[wr_idx[1:0]], wr_data, wr_strb);
          end
          // Any write to the counter clears it, strobes notwithstanding.
          cnt_clr = (wr_idx == REG_EVENT_CNT);
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    awready_d = (wr_state_d == WR_IDLE) && !aw_have_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_have_d;
  end

  // Read data mux over the pre-edge register values, so a same-cycle write returns old data.
  always_comb begin
    rd_word = 32'h0;
    case (S_AXI_ARADDR[4:2])
      REG_CTRL0:     rd_word = ctrl_q[0];
      REG_CTRL1:     rd_word = ctrl_q[1];
      REG_CTRL2:     rd_word = ctrl_q[2];
      REG_CTRL3:     rd_word = ctrl_q[3];
      REG_STATUS0:   rd_word = status0_i;
      REG_STATUS1:   rd_word = status1_i;
      REG_EVENT_CNT: rd_word = cnt_value;
      REG_ID:        rd_word = C_ID_VALUE;
      default:       rd_word = 32'h0;
    endcase
  end

  // Read FSM: latch data on AR handshake, hold it until the master takes it.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ar_hs      = S_AXI_ARVALID && arready_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rdata_d    = rd_word;
          rresp_d    = RESP_OKAY;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  // State and datapath registers for both channels.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= WR_IDLE;
      aw_have_q  <= 1'b0;
      aw_idx_q   <= 3'd0;
      w_have_q   <= 1'b0;
      w_data_q   <= 32'h0;
      w_strb_q   <= 4'h0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ctrl_q     <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_have_q  <= aw_have_d;
      aw_idx_q   <= aw_idx_d;
      w_have_q   <= w_have_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bresp_q    <= bresp_d;
      ctrl_q     <= ctrl_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl0_o       = ctrl_q[0];
  assign ctrl1_o       = ctrl_q[1];
  assign ctrl2_o       = ctrl_q[2];
  assign ctrl3_o       = ctrl_q[3];

endmodule

// File: tb/tb_bus_monitor_axil_slave.sv
// tb/tb_bus_monitor_axil_slave.sv - self-checking bench for bus_monitor_axil_slave
module tb_bus_monitor_axil_slave;

  localparam logic [31:0] ID_VALUE = 32'h0B05_0100;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic [31:0] status0 = '0, status1 = '0;
  logic        event_in = 1'b0;
  logic [31:0] ctrl0, ctrl1, ctrl2, ctrl3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ctrl [4];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  bus_monitor_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .status0_i(status0), .status1_i(status1), .event_i(event_in),
    .ctrl0_o(ctrl0), .ctrl1_o(ctrl1), .ctrl2_o(ctrl2), .ctrl3_o(ctrl3)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: return m_ctrl[idx[1:0]];
      3'd4: return status0;
      3'd5: return status1;
      3'd6: return m_cnt;
      default: return ID_VALUE;
    endcase
  endfunction

  task automatic m_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp);
    resp = OKAY;
    if (idx < 3'd4) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[idx[1:0]][8*b +: 8] = d[8*b +: 8];
    end else if (idx == 3'd6) begin
      m_cnt = 32'h0;
    end else begin
      resp = SLVERR;
    end
  endtask

  task automatic m_event();
    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic check_ctrls(input string tag);
    check({tag, "_ctrl0"}, ctrl0, m_ctrl[0]);
    check({tag, "_ctrl1"}, ctrl1, m_ctrl[1]);
    check({tag, "_ctrl2"}, ctrl2, m_ctrl[2]);
    check({tag, "_ctrl3"}, ctrl3, m_ctrl[3]);
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic wr_addr_data(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic aw_f, w_f;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(negedge clk);
      if (aw_f) awvalid = 1'b0;
      if (w_f) wvalid = 1'b0;
      n++;
    end
    check("aw_w_accept_timeout", {awvalid, wvalid}, 2'b00);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_bvalid();
    int n;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid_timeout", bvalid, 1'b1);
  endtask

  task automatic finish_b(output logic [1:0] resp);
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd_addr(input logic [4:0] a);
    int n;
    logic f;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 50) begin
      f = arready;
      @(negedge clk);
      if (f) arvalid = 1'b0;
      n++;
    end
    check("ar_accept_timeout", arvalid, 1'b0);
    arvalid = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("rvalid_timeout", rvalid, 1'b1);
  endtask

  task automatic finish_r(output logic [31:0] d, output logic [1:0] resp);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    wr_addr_data(a, d, s);
    wait_bvalid();
    finish_b(resp);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    rd_addr(a);
    wait_rvalid();
    finish_r(d, resp);
  endtask

  task automatic pulse_event();
    event_in = 1'b1;
    @(negedge clk);
    event_in = 1'b0;
    m_event();
  endtask

  initial begin
    logic [1:0]  r, er;
    logic [31:0] d, exp_d, v;
    logic [2:0]  idx;
    logic [4:0]  a;
    logic [3:0]  s;

    for (int i = 0; i < 4; i++) m_ctrl[i] = 32'h0;
    m_cnt = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check_ctrls("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic writes and read-back
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
      m_write(3'(i), 32'(i + 1), 4'hF, er);
      check("basic_bresp", r, er);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r);
      check("basic_rdata", d, m_read(3'(i)));
      check("basic_rresp", r, OKAY);
    end

    // W three cycles ahead of AW
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    check("wfirst_wready", wready, 1'b1);
    @(negedge clk);
    wvalid = 1'b0;
    check("wfirst_wready_drop", wready, 1'b0);
    check("wfirst_no_bvalid", bvalid, 1'b0);
    repeat (2) @(negedge clk);
    awaddr = 5'h04; awvalid = 1'b1;
    check("wfirst_awready", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst_b_latency", bvalid, 1'b1);
    finish_b(r);
    m_write(3'd1, 32'hDEAD_BEEF, 4'hF, er);
    check("wfirst_bresp", r, er);
    axi_read(5'h04, d, r);
    check("wfirst_rdata", d, m_read(3'd1));

    // Byte strobes
    axi_write(5'h08, 32'h0, 4'hF, r);
    m_write(3'd2, 32'h0, 4'hF, er);
    axi_write(5'h08, 32'hFFFF_FFFF, 4'b0101, r);
    m_write(3'd2, 32'hFFFF_FFFF, 4'b0101, er);
    check("strb_bresp", r, er);
    axi_read(5'h08, d, r);
    check("strb_rdata", d, m_read(3'd2));
    check_ctrls("strb");

    // Read-only words
    status0 = 32'h1234_5678;
    axi_write(5'h10, 32'hCAFE_F00D, 4'hF, r);
    m_write(3'd4, 32'hCAFE_F00D, 4'hF, er);
    check("ro_bresp", r, er);
    axi_read(5'h10, d, r);
    check("ro_status0", d, m_read(3'd4));
    axi_read(5'h1C, d, r);
    check("ro_id", d, m_read(3'd7));
    check_ctrls("ro");

    // Event counter
    for (int i = 0; i < 5; i++) pulse_event();
    axi_read(5'h18, d, r);
    check("cnt_five", d, m_read(3'd6));
    awaddr = 5'h18; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; event_in = 1'b1;
    check("cnt_clr_ready", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; event_in = 1'b0;
    m_event();
    m_write(3'd6, 32'h1234, 4'hF, er);
    wait_bvalid();
    finish_b(r);
    check("cnt_clr_bresp", r, er);
    axi_read(5'h18, d, r);
    check("cnt_clr_wins", d, m_read(3'd6));
    force dut.u_event_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_event_cnt.count_q;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    for (int i = 0; i < 3; i++) pulse_event();
    axi_read(5'h18, d, r);
    check("cnt_saturate", d, m_read(3'd6));

    // Backpressure on B and R
    wr_addr_data(5'h14, 32'h5555_AAAA, 4'hF);
    m_write(3'd5, 32'h5555_AAAA, 4'hF, er);
    wait_bvalid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b_hold", {bvalid, bresp}, {1'b1, er});
    end
    finish_b(r);
    status1 = 32'hA5A5_0001;
    exp_d = m_read(3'd5);
    rd_addr(5'h14);
    wait_rvalid();
    status1 = 32'h0F0F_0F0F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("r_hold", {rvalid, rresp, rdata}, {1'b1, OKAY, exp_d});
    end
    finish_r(d, r);

    // Same-register read and write committing together returns the old value
    exp_d = m_read(3'd0);
    awaddr = 5'h00; wdata = 32'h7777_1111; wstrb = 4'hF; araddr = 5'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    check("conc_ready", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_valids", {bvalid, rvalid}, 2'b11);
    check("conc_old_rdata", rdata, exp_d);
    m_write(3'd0, 32'h7777_1111, 4'hF, er);
    finish_b(r);
    finish_r(d, r);
    axi_read(5'h00, d, r);
    check("conc_new_rdata", d, m_read(3'd0));

    // Randomized traffic against the model
    status0 = $urandom;
    status1 = $urandom;
    for (int i = 0; i < 40; i++) begin
      idx = 3'($urandom_range(0, 7));
      a = {idx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, v, s, r);
        m_write(idx, v, s, er);
        check("rand_bresp", r, er);
        check_ctrls("rand");
      end else begin
        axi_read(a, d, r);
        check("rand_rdata", d, m_read(idx));
        check("rand_rresp", r, OKAY);
      end
    end

    // Reset in the middle of pending responses
    wr_addr_data(5'h00, 32'h0000_0055, 4'hF);
    m_write(3'd0, 32'h0000_0055, 4'hF, er);
    wait_bvalid();
    rd_addr(5'h04);
    wait_rvalid();
    check("prerst_ctrl0", ctrl0, m_ctrl[0]);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_ctrl[i] = 32'h0;
    m_cnt = 32'h0;
    check("midrst_valids", {bvalid, rvalid}, 2'b00);
    check_ctrls("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(5'h18, d, r);
    check("postrst_cnt", d, m_read(3'd6));
    axi_read(5'h00, d, r);
    check("postrst_ctrl0", d, m_read(3'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_monitor_axil_slave.md
Name: bus_monitor_axil_slave

Overview:
AXI4-Lite responder (slave) register block for the bus_monitor IP. It terminates the AXI4-Lite master port of the block design and implements 8 x 32-bit word registers:
- 4 read/write control/scratch registers.
- 2 read-only status words sampled from monitor logic.
- 1 saturating event counter.
- 1 constant ID word.

It sits between the AXI interconnect/VIP master and the bus_monitor core logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[4:2].
C_ID_VALUE, 32'hB05_0100, value returned by the ID register.

Ports:
S_AXI_ACLK  in  1  single clock; all logic on rising edge.
S_AXI_ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
status0_i  in  32  monitor status word 0.
status1_i  in  32  monitor status word 1.
event_i  in  1  single-cycle event pulse to count.
ctrl0_o..ctrl3_o  out  32 each  current values of the read/write registers 0-3.

Behaviour:
- Reset values (async assert, synchronous deassert release by upstream reset sync):
  - All READY/VALID outputs 0.
  - BRESP/RRESP 2'b00.
  - RDATA 0.
  - ctrl0..3 = 0.
  - Counter = 0.
- Register map (word index):
  - 0-3: RW, byte-strobed.
  - 4: status0_i (RO).
  - 5: status1_i (RO).
  - 6: event counter; a write of any value clears it.
  - 7: C_ID_VALUE (RO).
- Write channel FSM, states WR_IDLE / WR_RESP:
  - In WR_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured.
  - AW and W are accepted independently, in either order or in the same cycle.
  - The cycle after both are captured: perform the register update, set BVALID=1, enter WR_RESP. AWREADY/WREADY are 0 in WR_RESP.
  - BVALID holds with stable BRESP until BREADY; then return to WR_IDLE.
  - Minimum write latency: AW&W handshake in cycle N -> BVALID in cycle N+1.
- BRESP:
  - OKAY for indices 0-3 and 6.
  - SLVERR for indices 4, 5, 7; register contents are unchanged.
  - WSTRB=0 -> OKAY, no change (counter clear still applies for index 6).
- Read channel FSM, states RD_IDLE / RD_DATA:
  - ARREADY=1 in RD_IDLE.
  - On the AR handshake in cycle N, RDATA is sampled from the register values at the end of cycle N; RVALID=1 and RRESP=OKAY in cycle N+1.
  - RDATA/RRESP stay stable until RREADY; ARREADY=0 while in RD_DATA.
- Read and write channels are fully concurrent. A same-register read and write commit in the same cycle returns the old value.
- Counter:
  - +1 per event_i cycle; saturates at 32'hFFFF_FFFF with no wrap.
  - Clear write coinciding with event_i -> result 0 (clear wins).
- Address bits [1:0] are ignored; unaligned addresses are treated as aligned.
- Reset asserted mid-transaction: all FSMs return to IDLE immediately and any pending response is dropped.

Decomposition:
- Package bus_monitor_pkg holds:
  - Register index localparams (REG_CTRL0..REG_ID).
  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State enums wr_state_t and rd_state_t.
- One sub-module, bus_monitor_event_cnt: the saturating counter with clear-priority. Everything else stays flat.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to addresses 0x00,0x04,0x08,0x0C, then read them back -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY.
- W presented 3 cycles before AW at 0x04 with data 0xDEADBEEF -> WREADY drops after W capture; BVALID exactly 1 cycle after the AW handshake; reading 0x04 returns 0xDEADBEEF.
- Write 0xFFFFFFFF with WSTRB=4'b0101 to 0x08 holding 0x0 -> reads back 0x00FF00FF.
- Write to 0x10 (status0) while status0_i=0x12345678 -> BRESP=SLVERR; reading 0x10 returns 0x12345678; reading 0x1C returns C_ID_VALUE.
- Pulse event_i 5 times, read 0x18 -> 5; write 0x18 in the same cycle as an event -> subsequent read 0. Force counter to 0xFFFFFFFE and pulse 3 times -> 0xFFFFFFFF.
- Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and BRESP/RDATA stable. Assert ARESETN low mid-response -> BVALID/RVALID=0 and ctrl0..3=0 within the same cycle.
